mem_port_arbiter: RTL

//  Shares one single-port instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data side wins by default; a streak counter guarantees fetch a slot.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    IF_Req,
    input  logic [ADDR_WIDTH-1:0]   IF_Addr,
    input  logic                    IF_Abort,
    output logic                    IF_Ack,
    output logic [DATA_WIDTH-1:0]   IF_Rdata,
    output logic                    IF_Stall,
    input  logic                    D_Req,
    input  logic                    D_We,
    input  logic [DATA_WIDTH/8-1:0] D_Be,
    input  logic [ADDR_WIDTH-1:0]   D_Addr,
    input  logic [DATA_WIDTH-1:0]   D_Wdata,
    output logic                    D_Ack,
    output logic [DATA_WIDTH-1:0]   D_Rdata,
    output logic                    D_Stall,
    output logic                    Mem_En,
    output logic                    Mem_We,
    output logic [DATA_WIDTH/8-1:0] Mem_Be,
    output logic [ADDR_WIDTH-1:0]   Mem_Addr,
    output logic [DATA_WIDTH-1:0]   Mem_Wdata,
    input  logic [DATA_WIDTH-1:0]   Mem_Rdata
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [CW-1:0] LAT_CNT    = CW'(MEM_LATENCY);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_D  = 2'd1,
        S_BUSY_IF = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_wait_cnt;
    logic [SW-1:0]   r_streak;
    logic            r_drop;
    logic            r_mem_we;
    logic [BW-1:0]   r_mem_be;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic w_if_live, w_busy, w_done, w_grant_d, w_grant_if;

    assign w_if_live = IF_Req & ~IF_Abort;
    assign w_busy    = (r_state != S_IDLE);
    assign w_done    = w_busy && (r_wait_cnt == LAT_CNT);

    always_ff @(posedge Clk) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_if  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Fetch wins only once the data side has used up its streak.
                if (D_Req && !(w_if_live && r_streak == STREAK_MAX)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_BUSY_D;
                end else if (w_if_live) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = S_BUSY_IF;
                end
            end
            S_BUSY_D, S_BUSY_IF: begin
                if (w_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_wait_cnt  <= '0;
            r_streak    <= '0;
            r_drop      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_grant_d) begin
                r_wait_cnt  <= '0;
                r_mem_we    <= D_We;
                r_mem_be    <= D_Be;
                r_mem_addr  <= D_Addr;
                r_mem_wdata <= D_Wdata;
            end else if (w_grant_if) begin
                r_wait_cnt  <= '0;
                r_mem_we    <= 1'b0;
                r_mem_be    <= '1;
                r_mem_addr  <= IF_Addr;
                r_mem_wdata <= '0;
            end else if (w_done) begin
                r_wait_cnt  <= '0;
                r_mem_we    <= 1'b0;
                r_mem_be    <= '0;
                r_mem_addr  <= '0;
                r_mem_wdata <= '0;
            end else if (w_busy) begin
                r_wait_cnt  <= r_wait_cnt + CW'(1);
            end

            if (w_grant_d) begin
                if (!IF_Req)                      r_streak <= '0;
                else if (r_streak != STREAK_MAX)  r_streak <= r_streak + SW'(1);
            end else if (w_grant_if) begin
                r_streak <= '0;
            end

            // The redirected fetch still occupies the port; only its ack is lost.
            if (w_done)                                r_drop <= 1'b0;
            else if (r_state == S_BUSY_IF && IF_Abort) r_drop <= 1'b1;
        end
    end

    assign Mem_En    = w_busy && (r_wait_cnt == '0);
    assign Mem_We    = r_mem_we;
    assign Mem_Be    = r_mem_be;
    assign Mem_Addr  = r_mem_addr;
    assign Mem_Wdata = r_mem_wdata;

    assign D_Ack    = (r_state == S_BUSY_D) && w_done;
    assign IF_Ack   = (r_state == S_BUSY_IF) && w_done && !r_drop && !IF_Abort;
    assign D_Rdata  = Mem_Rdata;
    assign IF_Rdata = Mem_Rdata;
    assign D_Stall  = D_Req & ~D_Ack;
    assign IF_Stall = IF_Req & ~IF_Ack;

endmodule
